// File: rtl/redmule_tcdm_stream_arbiter.sv
// redmule_tcdm_stream_arbiter: shares one TCDM port between X/W/Y/Z streams with RR, urgency and anti-starvation
module redmule_tcdm_stream_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 256,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned StarveLimit    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        we_i,
  input  logic [NumReq*AW-1:0]     addr_i,
  input  logic [NumReq*DW-1:0]     wdata_i,
  input  logic [NumReq*DW/8-1:0]   be_i,
  input  logic [NumReq-1:0]        urgent_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic [DW-1:0]            rdata_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic                     mem_we_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DW-1:0]            mem_wdata_o,
  output logic [DW/8-1:0]          mem_be_o,
  input  logic                     mem_rvalid_i,
  input  logic [DW-1:0]            mem_rdata_i,
  output logic                     busy_o,
  output logic                     err_o
);
  localparam int IW = NumReq > 1 ? $clog2(NumReq) : 1;
  localparam int PW = $clog2(MaxOutstanding);
  localparam int CW = $clog2(MaxOutstanding) + 1;
  localparam int SW = $clog2(StarveLimit + 1);
  logic [IW-1:0]     ptr_q, sel, lo, head;
  logic [SW-1:0]     starve_q [NumReq];
  logic [IW-1:0]     fifo_q [MaxOutstanding];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q, full, empty, push, pop;
  logic [NumReq-1:0] starved, urg_req;
  // round-robin pick: first set bit of m at or after p, wrapping
  function automatic logic [IW-1:0] rr_pick(input logic [NumReq-1:0] m, input logic [IW-1:0] p);
    int idx;
    rr_pick = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= int'(NumReq)) idx -= int'(NumReq);
      if (m[idx]) rr_pick = IW'(idx);
    end
  endfunction
  assign full    = cnt_q == CW'(MaxOutstanding);
  assign empty   = cnt_q == '0;
  assign urg_req = req_i & urgent_i;
  assign mem_req_o = |req_i & ~full;
  assign push    = mem_req_o & mem_gnt_i;
  assign pop     = mem_rvalid_i & ~empty;
  assign head    = fifo_q[rptr_q];
  assign busy_o  = ~empty;
  assign err_o   = err_q;
  assign rdata_o = pop ? mem_rdata_i : '0;
  assign mem_we_o    = we_i[sel];
  assign mem_addr_o  = addr_i[sel*AW +: AW];
  assign mem_wdata_o = wdata_i[sel*DW +: DW];
  assign mem_be_o    = be_i[sel*(DW/8) +: DW/8];
  // selection: starved lowest index, then urgent round-robin, then plain round-robin
  always_comb begin
    starved = '0;
    lo = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      starved[i] = req_i[i] && starve_q[i] == SW'(StarveLimit);
      if (starved[i]) lo = IW'(i);
    end
    sel = |starved ? lo : |urg_req ? rr_pick(urg_req, ptr_q) : rr_pick(req_i, ptr_q);
  end
  // one-hot grant and response routing to the stream at the ID FIFO head
  always_comb begin
    gnt_o = '0;
    rvalid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      gnt_o[i] = push && sel == IW'(i);
      rvalid_o[i] = pop && head == IW'(i);
    end
  end
  // ID FIFO storage needs no reset: only entries below the count are ever read
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= sel;
  end
  // pointer, FIFO bookkeeping, starvation counters and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NumReq; i++) starve_q[i] <= '0;
    end else if (clear_i) begin
      ptr_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NumReq; i++) starve_q[i] <= '0;
    end else begin
      if (push) begin
        ptr_q  <= sel == IW'(NumReq - 1) ? '0 : sel + 1'b1;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (mem_rvalid_i && empty) err_q <= 1'b1;
      for (int i = 0; i < NumReq; i++) begin
        if (!req_i[i] || (push && sel == IW'(i))) starve_q[i] <= '0;
        else if (!full && starve_q[i] != SW'(StarveLimit)) starve_q[i] <= starve_q[i] + 1'b1;
      end
    end
  end
endmodule
